jogador_automatico: RTL and testbench
=====================================

JOGADOR_AUTOMATICO -- requirements
Module: jogador_automatico

Interface
REQ-001 The block SHALL have parameter T_PRESS, default 1000, giving the clock cycles a button is held.
REQ-002 The block SHALL have parameter T_GAP, default 500, giving the clock cycles between presses and before the first press.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port habilita, input, 1 bit: enables the auto-player.
REQ-006 The block SHALL have port mostra, input, 1 bit: high while the game presents its sequence on leds.
REQ-007 The block SHALL have port leds, input, 4 bits: game LED outputs, one-hot or zero.
REQ-008 The block SHALL have port botoes, output, 4 bits: emulated button presses toward the game.
REQ-009 The block SHALL have port pronto, output, 1 bit: one-cycle pulse when a round's replay completes.
REQ-010 The block SHALL have port erro, output, 1 bit: sticky flag for a non-one-hot pattern or buffer overflow.
REQ-011 The block SHALL have port db_estado, output, 4 bits: current state code.
REQ-012 The block SHALL have port db_contagem, output, 4 bits: current replay read pointer.

Function
REQ-013 The block SHALL have states OCIOSO=0, OBSERVA=1, ESPERA=2, PRESSIONA=3, SOLTA=4, FIM=F (hex), reported on db_estado.
REQ-014 In OCIOSO, habilita=1 SHALL move to OBSERVA and clear the entry count, read pointer, timer and erro.
REQ-015 In OBSERVA, with mostra=1, leds nonzero and the previous-cycle leds zero (capture edge), the block SHALL write leds into buffer[count] at that edge and increment count.
REQ-016 A captured pattern that is not one-hot SHALL NOT be stored and SHALL set erro.
REQ-017 Buffer depth SHALL be 16; a capture edge at count=16 SHALL be dropped and SHALL set erro.
REQ-018 A falling edge of mostra in OBSERVA with count>0 SHALL move to ESPERA; with count=0 the block SHALL stay in OBSERVA.
REQ-019 ESPERA SHALL last exactly T_GAP cycles, then move to PRESSIONA.
REQ-020 PRESSIONA SHALL drive botoes=buffer[rd_ptr] for exactly T_PRESS cycles, then move to SOLTA.
REQ-021 SOLTA SHALL drive botoes=0 for T_GAP cycles and then increment rd_ptr; it SHALL then move to PRESSIONA if rd_ptr<count, else to FIM.
REQ-022 FIM SHALL last one cycle with pronto=1, clear count and rd_ptr (erro kept), and move to OBSERVA for the next round.
REQ-023 botoes SHALL be registered and be 0 in every state except PRESSIONA.
REQ-024 habilita=0 in any state SHALL force OCIOSO on the next edge with botoes=0; buffer contents need not be preserved.
REQ-025 Capture edges in any state other than OBSERVA SHALL be ignored.
REQ-026 The block SHALL treat mostra and leds as synchronous to clock and SHALL NOT synchronize them.

Reset
REQ-027 reset=0 SHALL asynchronously force OCIOSO, botoes=0, pronto=0, erro=0, count=0, rd_ptr=0, timer=0 and the previous-leds register to 0.
REQ-028 Reset asserted mid-press SHALL release botoes immediately, without waiting for a clock edge.
REQ-029 Buffer storage SHALL NOT require reset.

Structure
REQ-030 State codes and buffer depth SHALL live in a shared include, jogador_automatico_defs, for reuse by the bench.
REQ-031 T_PRESS and T_GAP timing SHALL be produced by one instance of the existing contador_m, sized to max(T_PRESS,T_GAP); the FSM and the 16x4 buffer SHALL stay in this module.

Verification (bench: T_PRESS=4, T_GAP=2)
REQ-032 Directed test: reset low mid-PRESSIONA -> botoes=0000 and db_estado=0 before the next edge.
REQ-033 Directed test: habilita=1; mostra=1; leds 0001,0000,0100,0000; mostra=0 -> ESPERA 2 cycles, botoes=0001 for 4 cycles, 0 for 2, 0100 for 4, 0 for 2, pronto one cycle, db_estado back to 1.
REQ-034 Directed test: leds held at 0010 for 5 cycles during mostra -> exactly one entry captured, one 4-cycle press.
REQ-035 Directed test: 17 capture edges -> erro=1, 16 presses replayed, db_contagem wraps to 0 at FIM.
REQ-036 Directed test: leds=0110 captured -> erro=1, entry not stored, replay omits it.
REQ-037 Directed test: habilita dropped during SOLTA -> OCIOSO next cycle, no further botoes activity, pronto stays 0.

Source files
------------

// File: rtl/jogador_automatico_defs.sv
// Shared definitions for the auto-player: state codes, replay buffer geometry
// and the one-hot test applied to captured LED patterns.
package jogador_automatico_defs;

  localparam int BUF_DEPTH = 16;
  localparam int BUF_AW    = 4;
  // One extra bit so the entry count can represent a completely full buffer.
  localparam int CNT_W     = BUF_AW + 1;

  typedef enum logic [3:0] {
    OCIOSO    = 4'h0,
    OBSERVA   = 4'h1,
    ESPERA    = 4'h2,
    PRESSIONA = 4'h3,
    SOLTA     = 4'h4,
    FIM       = 4'hF
  } estado_t;

  function automatic logic is_one_hot(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

endpackage

// File: rtl/contador_m.sv
// Modulo-M up counter with synchronous clear (zera) and count enable (conta).
// The clear wins over the enable, so a state change can restart the count.
module contador_m #(
  parameter int M = 16,
  parameter int N = (M > 1) ? $clog2(M) : 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera,
  input  logic         conta,
  output logic [N-1:0] q
);

  logic [N-1:0] q_q;
  logic [N-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (zera) begin
      q_d = '0;
    end else if (conta) begin
      q_d = (q_q == N'(M - 1)) ? '0 : q_q + N'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/jogador_automatico.sv
// Auto-player: records the LED sequence the game shows, then replays it as
// timed button presses and pulses pronto once the round is done.
module jogador_automatico
  import jogador_automatico_defs::*;
#(
  parameter int T_PRESS = 1000,
  parameter int T_GAP   = 500
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       habilita,
  input  logic       mostra,
  input  logic [3:0] leds,
  output logic [3:0] botoes,
  output logic       pronto,
  output logic       erro,
  output logic [3:0] db_estado,
  output logic [3:0] db_contagem
);

  localparam int T_MAX = (T_PRESS > T_GAP) ? T_PRESS : T_GAP;
  localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam logic [TW-1:0] ULTIMO_PRESS = TW'(T_PRESS - 1);
  localparam logic [TW-1:0] ULTIMO_GAP   = TW'(T_GAP - 1);

  estado_t          estado_q, estado_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [3:0]       botoes_q, botoes_d;
  logic [3:0]       leds_prev_q;
  logic             mostra_prev_q;
  logic             pronto_q, pronto_d;
  logic             erro_q, erro_d;

  logic [3:0]       buffer_mem [BUF_DEPTH];
  logic             buf_we;

  logic [TW-1:0]    timer_q;
  logic             timer_zera, timer_conta;
  logic             fim_gap, fim_press;
  logic             cap_edge, mostra_fall;

  contador_m #(
    .M(T_MAX),
    .N(TW)
  ) u_timer (
    .clock (clock),
    .reset (reset),
    .zera  (timer_zera),
    .conta (timer_conta),
    .q     (timer_q)
  );

  // A capture happens on the first cycle a pattern lights up while shown.
  assign cap_edge    = mostra && (leds != 4'b0000) && (leds_prev_q == 4'b0000);
  assign mostra_fall = mostra_prev_q && !mostra;
  assign fim_gap     = (timer_q == ULTIMO_GAP);
  assign fim_press   = (timer_q == ULTIMO_PRESS);

  always_comb begin
    estado_d    = estado_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    erro_d      = erro_q;
    buf_we      = 1'b0;
    timer_zera  = 1'b0;
    timer_conta = 1'b0;

    case (estado_q)
      OCIOSO: begin
        timer_zera = 1'b1;
        if (habilita) begin
          estado_d = OBSERVA;
          count_d  = '0;
          rd_ptr_d = '0;
          erro_d   = 1'b0;
        end
      end

      OBSERVA: begin
        // Holding the timer at zero means ESPERA always starts a fresh count.
        timer_zera = 1'b1;
        if (cap_edge) begin
          if (!is_one_hot(leds) || (count_q == CNT_W'(BUF_DEPTH))) begin
            erro_d = 1'b1;
          end else begin
            buf_we  = 1'b1;
            count_d = count_q + CNT_W'(1);
          end
        end else if (mostra_fall && (count_q != '0)) begin
          estado_d = ESPERA;
        end
      end

      ESPERA: begin
        timer_conta = 1'b1;
        if (fim_gap) begin
          timer_zera = 1'b1;
          estado_d   = PRESSIONA;
        end
      end

      PRESSIONA: begin
        timer_conta = 1'b1;
        if (fim_press) begin
          timer_zera = 1'b1;
          estado_d   = SOLTA;
        end
      end

      SOLTA: begin
        timer_conta = 1'b1;
        if (fim_gap) begin
          timer_zera = 1'b1;
          rd_ptr_d   = rd_ptr_q + CNT_W'(1);
          estado_d   = (rd_ptr_d < count_q) ? PRESSIONA : FIM;
        end
      end

      FIM: begin
        timer_zera = 1'b1;
        count_d    = '0;
        rd_ptr_d   = '0;
        estado_d   = OBSERVA;
      end

      default: begin
        timer_zera = 1'b1;
        estado_d   = OCIOSO;
      end
    endcase

    if (!habilita) begin
      estado_d = OCIOSO;
      buf_we   = 1'b0;
    end

    // Outputs follow the next state so they line up with the registered state.
    pronto_d = (estado_d == FIM);
    botoes_d = (estado_d == PRESSIONA) ? buffer_mem[rd_ptr_d[BUF_AW-1:0]] : 4'b0000;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q      <= OCIOSO;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      botoes_q      <= 4'b0000;
      pronto_q      <= 1'b0;
      erro_q        <= 1'b0;
      leds_prev_q   <= 4'b0000;
      mostra_prev_q <= 1'b0;
    end else begin
      estado_q      <= estado_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      botoes_q      <= botoes_d;
      pronto_q      <= pronto_d;
      erro_q        <= erro_d;
      leds_prev_q   <= leds;
      mostra_prev_q <= mostra;
    end
  end

  always_ff @(posedge clock) begin
    if (buf_we) begin
      buffer_mem[count_q[BUF_AW-1:0]] <= leds;
    end
  end

  assign botoes      = botoes_q;
  assign pronto      = pronto_q;
  assign erro        = erro_q;
  assign db_estado   = estado_q;
  assign db_contagem = rd_ptr_q[BUF_AW-1:0];

endmodule

// File: tb/tb_jogador_automatico.sv
// Directed bench for jogador_automatico with T_PRESS=4 and T_GAP=2.
module tb_jogador_automatico;
  import jogador_automatico_defs::*;

  localparam logic [3:0] S_OCIOSO    = 4'h0;
  localparam logic [3:0] S_OBSERVA   = 4'h1;
  localparam logic [3:0] S_ESPERA    = 4'h2;
  localparam logic [3:0] S_PRESSIONA = 4'h3;
  localparam logic [3:0] S_SOLTA     = 4'h4;
  localparam logic [3:0] S_FIM       = 4'hF;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       habilita = 1'b0;
  logic       mostra = 1'b0;
  logic [3:0] leds = 4'b0000;
  logic [3:0] botoes;
  logic       pronto;
  logic       erro;
  logic [3:0] db_estado;
  logic [3:0] db_contagem;

  int pass_count  = 0;
  int total_count = 0;

  jogador_automatico #(
    .T_PRESS(4),
    .T_GAP  (2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .habilita    (habilita),
    .mostra      (mostra),
    .leds        (leds),
    .botoes      (botoes),
    .pronto      (pronto),
    .erro        (erro),
    .db_estado   (db_estado),
    .db_contagem (db_contagem)
  );

  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total_count++;
    assert (obs === exp) pass_count++;
    else $error("FAIL %s observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total_count++;
    assert (obs === exp) pass_count++;
    else $error("FAIL %s observed %b expected %b", tag, obs, exp);
  endtask

  // n cycles of a steady state: checks state, buttons, read pointer, pronto low.
  task automatic run(input string tag, input logic [3:0] est, input logic [3:0] bot,
                     input logic [3:0] cnt, input int n);
    for (int k = 0; k < n; k++) begin
      cyc();
      chk4({tag, "_estado"}, db_estado, est);
      chk4({tag, "_botoes"}, botoes, bot);
      chk4({tag, "_contagem"}, db_contagem, cnt);
      chk1({tag, "_pronto"}, pronto, 1'b0);
    end
  endtask

  task automatic show(input logic [3:0] p);
    leds = p;
    cyc();
    leds = 4'b0000;
    cyc();
  endtask

  task automatic end_round(input string tag, input logic [3:0] cnt_fim);
    cyc();
    chk4({tag, "_fim_estado"}, db_estado, S_FIM);
    chk1({tag, "_fim_pronto"}, pronto, 1'b1);
    chk4({tag, "_fim_contagem"}, db_contagem, cnt_fim);
    chk4({tag, "_fim_botoes"}, botoes, 4'b0000);
    cyc();
    chk4({tag, "_volta_estado"}, db_estado, S_OBSERVA);
    chk1({tag, "_volta_pronto"}, pronto, 1'b0);
    chk4({tag, "_volta_contagem"}, db_contagem, 4'h0);
  endtask

  task automatic restart();
    habilita = 1'b0;
    cyc();
    chk4("restart_ocioso", db_estado, S_OCIOSO);
    habilita = 1'b1;
    cyc();
    chk4("restart_observa", db_estado, S_OBSERVA);
    chk1("restart_erro", erro, 1'b0);
  endtask

  initial begin
    logic [3:0] p;

    // Reset state
    #2 reset = 1'b0;
    cyc();
    cyc();
    chk4("rst_estado", db_estado, S_OCIOSO);
    chk4("rst_botoes", botoes, 4'b0000);
    chk1("rst_pronto", pronto, 1'b0);
    chk1("rst_erro", erro, 1'b0);
    chk4("rst_contagem", db_contagem, 4'h0);
    reset = 1'b1;
    cyc();
    chk4("idle_without_enable", db_estado, S_OCIOSO);
    habilita = 1'b1;
    cyc();
    chk4("enable_observa", db_estado, S_OBSERVA);
    $display("reset and enable done");

    // Two-entry round: 0001 then 0100
    mostra = 1'b1;
    cyc();
    show(4'b0001);
    show(4'b0100);
    mostra = 1'b0;
    run("r1_espera", S_ESPERA, 4'b0000, 4'h0, 2);
    run("r1_press0", S_PRESSIONA, 4'b0001, 4'h0, 4);
    run("r1_solta0", S_SOLTA, 4'b0000, 4'h0, 2);
    run("r1_press1", S_PRESSIONA, 4'b0100, 4'h1, 4);
    run("r1_solta1", S_SOLTA, 4'b0000, 4'h1, 2);
    end_round("r1", 4'h2);
    chk1("r1_erro", erro, 1'b0);
    $display("round two-entry replayed");

    // A pattern held for 5 cycles yields a single entry
    mostra = 1'b1;
    cyc();
    leds = 4'b0010;
    for (int k = 0; k < 5; k++) cyc();
    leds = 4'b0000;
    cyc();
    mostra = 1'b0;
    run("r2_espera", S_ESPERA, 4'b0000, 4'h0, 2);
    run("r2_press0", S_PRESSIONA, 4'b0010, 4'h0, 4);
    run("r2_solta0", S_SOLTA, 4'b0000, 4'h0, 2);
    end_round("r2", 4'h1);
    chk1("r2_erro", erro, 1'b0);
    $display("round held-pattern replayed");

    // Non-one-hot pattern is flagged and dropped
    mostra = 1'b1;
    cyc();
    leds = 4'b0110;
    cyc();
    chk1("r3_erro_set", erro, 1'b1);
    leds = 4'b0000;
    cyc();
    show(4'b1000);
    mostra = 1'b0;
    run("r3_espera", S_ESPERA, 4'b0000, 4'h0, 2);
    run("r3_press0", S_PRESSIONA, 4'b1000, 4'h0, 4);
    run("r3_solta0", S_SOLTA, 4'b0000, 4'h0, 2);
    end_round("r3", 4'h1);
    chk1("r3_erro_sticky", erro, 1'b1);
    $display("round bad-pattern replayed");

    // Overflow: 17 capture edges, 16 replayed
    restart();
    mostra = 1'b1;
    cyc();
    for (int i = 0; i < BUF_DEPTH; i++) begin
      p = 4'b0001 << (i % 4);
      show(p);
    end
    chk1("r4_erro_full", erro, 1'b0);
    show(4'b1000);
    chk1("r4_erro_overflow", erro, 1'b1);
    mostra = 1'b0;
    run("r4_espera", S_ESPERA, 4'b0000, 4'h0, 2);
    for (int i = 0; i < BUF_DEPTH; i++) begin
      p = 4'b0001 << (i % 4);
      run("r4_press", S_PRESSIONA, p, i[3:0], 4);
      run("r4_solta", S_SOLTA, 4'b0000, i[3:0], 2);
    end
    end_round("r4", 4'h0);
    $display("round overflow replayed");

    // habilita dropped during SOLTA
    restart();
    mostra = 1'b1;
    cyc();
    show(4'b0001);
    show(4'b0010);
    mostra = 1'b0;
    run("r5_espera", S_ESPERA, 4'b0000, 4'h0, 2);
    run("r5_press0", S_PRESSIONA, 4'b0001, 4'h0, 4);
    run("r5_solta0", S_SOLTA, 4'b0000, 4'h0, 1);
    habilita = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk4("r5_off_estado", db_estado, S_OCIOSO);
      chk4("r5_off_botoes", botoes, 4'b0000);
      chk1("r5_off_pronto", pronto, 1'b0);
    end
    $display("round disable-in-solta done");

    // Asynchronous reset in the middle of a press
    habilita = 1'b1;
    cyc();
    chk4("r6_observa", db_estado, S_OBSERVA);
    mostra = 1'b1;
    cyc();
    show(4'b0010);
    mostra = 1'b0;
    run("r6_espera", S_ESPERA, 4'b0000, 4'h0, 2);
    run("r6_press0", S_PRESSIONA, 4'b0010, 4'h0, 2);
    #2 reset = 1'b0;
    #1;
    chk4("r6_async_botoes", botoes, 4'b0000);
    chk4("r6_async_estado", db_estado, S_OCIOSO);
    chk1("r6_async_pronto", pronto, 1'b0);
    chk4("r6_async_contagem", db_contagem, 4'h0);
    cyc();
    reset = 1'b1;
    cyc();
    chk4("r6_after_reset", db_estado, S_OBSERVA);
    $display("round async-reset done");

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule
